// File: rtl/sfc_pkg.sv
// Shared types and constants for the shift-register frame controller.
package sfc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_HOLD    = 3'd4
  } state_e;

  localparam int unsigned FRAME_CNT_W = 16;

endpackage

// File: rtl/shift_frame_controller_if.sv
// Frame-start/serial strobe inputs and the downstream valid/ready word channel.
interface shift_frame_controller_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             frame_start;
  logic             serial_in;
  logic             serial_valid;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;

  // Environment side: front end plus word consumer.
  modport master (
    output frame_start,
    output serial_in,
    output serial_valid,
    output word_ready,
    input  word_out,
    input  word_valid
  );

  // Controller side.
  modport slave (
    input  frame_start,
    input  serial_in,
    input  serial_valid,
    input  word_ready,
    output word_out,
    output word_valid
  );

endinterface

// File: rtl/sfc_bit_timer.sv
// Counts accepted bits of a frame and idle cycles between strobes; both counters saturate.
module sfc_bit_timer #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic run_i,
  input  logic strobe_i,
  output logic done_o,
  output logic timeout_o
);

  localparam int unsigned BitCntW  = $clog2(WIDTH + 1);
  localparam int unsigned IdleCntW = $clog2(TIMEOUT + 1);

  localparam logic [BitCntW-1:0]  BitLast  = BitCntW'(WIDTH - 1);
  localparam logic [BitCntW-1:0]  BitMax   = BitCntW'(WIDTH);
  localparam logic [IdleCntW-1:0] IdleLast = IdleCntW'(TIMEOUT - 1);
  localparam logic [IdleCntW-1:0] IdleMax  = IdleCntW'(TIMEOUT);

  logic [BitCntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [IdleCntW-1:0] idle_cnt_q, idle_cnt_d;

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    idle_cnt_d = idle_cnt_q;
    if (clear_i) begin
      bit_cnt_d  = '0;
      idle_cnt_d = '0;
    end else if (run_i) begin
      if (strobe_i) begin
        bit_cnt_d  = (bit_cnt_q == BitMax) ? BitMax : bit_cnt_q + BitCntW'(1);
        idle_cnt_d = '0;
      end else begin
        idle_cnt_d = (idle_cnt_q == IdleMax) ? IdleMax : idle_cnt_q + IdleCntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bit_cnt_q  <= '0;
      idle_cnt_q <= '0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign done_o    = run_i && strobe_i && (bit_cnt_q == BitLast);
  // A silent cycle with the counter at its last value ends the frame.
  assign timeout_o = run_i && !strobe_i && (idle_cnt_q >= IdleLast);

endmodule

// File: rtl/sfc_shift_reg.sv
// Serial-in/parallel-out shift register, first bit ends up in the MSB.
module sfc_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             shift_enable_i,
  input  logic             data_i,
  output logic [WIDTH-1:0] stored_data_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      data_q <= '0;
    end else if (shift_enable_i) begin
      data_q <= {data_q[WIDTH-2:0], data_i};
    end
  end

  assign stored_data_o = data_q;

endmodule

// File: rtl/shift_frame_controller.sv
// Sequences an external shift register through clear/shift/capture and hands the word
// downstream on valid/ready, reporting overrun and bit-timeout conditions.
module shift_frame_controller
  import sfc_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  shift_frame_controller_if.slave bus,
  output logic                   sr_reset_n_o,
  output logic                   sr_shift_enable_o,
  output logic                   sr_data_o,
  input  logic [WIDTH-1:0]       sr_stored_data_i,
  output logic                   busy_o,
  output logic                   overrun_o,
  output logic                   timeout_err_o,
  output logic [FRAME_CNT_W-1:0] frame_count_o
);

  state_e                 state_q;
  logic [WIDTH-1:0]       word_q;
  logic                   word_valid_q;
  logic                   overrun_q;
  logic                   timeout_err_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;

  logic bits_done;
  logic bit_timeout;
  logic handshake;

  sfc_bit_timer #(
    .WIDTH  (WIDTH),
    .TIMEOUT(TIMEOUT)
  ) u_bit_timer (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clear_i  (state_q == ST_CLEAR),
    .run_i    (state_q == ST_SHIFT),
    .strobe_i (bus.serial_valid),
    .done_o   (bits_done),
    .timeout_o(bit_timeout)
  );

  assign handshake = word_valid_q && bus.word_ready;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      word_q        <= '0;
      word_valid_q  <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      timeout_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.frame_start) state_q <= ST_CLEAR;
        end
        ST_CLEAR: begin
          state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          // A restart wins over both the final bit and the timeout.
          if (bus.frame_start) begin
            state_q <= ST_CLEAR;
          end else if (bits_done) begin
            state_q <= ST_CAPTURE;
          end else if (bit_timeout) begin
            state_q       <= ST_IDLE;
            timeout_err_q <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          word_q       <= sr_stored_data_i;
          word_valid_q <= 1'b1;
          state_q      <= ST_HOLD;
        end
        ST_HOLD: begin
          if (handshake) begin
            word_valid_q <= 1'b0;
            frame_cnt_q  <= frame_cnt_q + FRAME_CNT_W'(1);
            state_q      <= bus.frame_start ? ST_CLEAR : ST_IDLE;
          end else if (bus.frame_start) begin
            overrun_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // The shift register is cleared alongside this block and on every frame start.
  assign sr_reset_n_o      = !(reset_i || (state_q == ST_CLEAR));
  assign sr_shift_enable_o = (state_q == ST_SHIFT) && bus.serial_valid;
  assign sr_data_o         = bus.serial_in;

  assign bus.word_out   = word_q;
  assign bus.word_valid = word_valid_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign overrun_o      = overrun_q;
  assign timeout_err_o  = timeout_err_q;
  assign frame_count_o  = frame_cnt_q;

  a_valid_iff_hold : assert property (@(posedge clk_i) disable iff (reset_i)
    word_valid_q == (state_q == ST_HOLD));

  a_word_stable : assert property (@(posedge clk_i) disable iff (reset_i)
    (state_q == ST_HOLD) && !handshake |=> $stable(word_q));

  a_shift_only_in_shift : assert property (@(posedge clk_i)
    sr_shift_enable_o |-> (state_q == ST_SHIFT));

endmodule
